// File: rtl/filter_pingpong_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : filter_pingpong_buffer_if
// Brief    : Loader write stream, PE filter-fetch bus and slot control/status
//            bundle for filter_pingpong_buffer.
// Revision : 1.0
// ============================================================================
interface filter_pingpong_buffer_if #(
    parameter int FILTER_DW     = 72,
    parameter int FILTER_BUF_AW = 8,
    parameter int W_SIZE        = 16
);
    // Tile configuration
    logic [W_SIZE-1:0]        q_channel;

    // Loader stream
    logic                     i_w_valid;
    logic                     o_w_ready;
    logic [FILTER_DW-1:0]     i_w_data;

    // PE fetch bus
    logic                     o_fb_req_possible;
    logic                     i_fb_req;
    logic [FILTER_BUF_AW-1:0] i_fb_addr;
    logic [FILTER_DW-1:0]     o_fb_data0;
    logic [FILTER_DW-1:0]     o_fb_data1;
    logic [FILTER_DW-1:0]     o_fb_data2;
    logic [FILTER_DW-1:0]     o_fb_data3;
    logic                     o_fb_data_vld;

    // Slot control / status
    logic                     i_tile_release;
    logic [1:0]               o_slot_full;
    logic                     o_rd_err;

    // Loader / PE / controller side
    modport master (
        output q_channel, i_w_valid, i_w_data, i_fb_req, i_fb_addr, i_tile_release,
        input  o_w_ready, o_fb_req_possible, o_fb_data0, o_fb_data1, o_fb_data2,
               o_fb_data3, o_fb_data_vld, o_slot_full, o_rd_err
    );

    // Buffer side
    modport slave (
        input  q_channel, i_w_valid, i_w_data, i_fb_req, i_fb_addr, i_tile_release,
        output o_w_ready, o_fb_req_possible, o_fb_data0, o_fb_data1, o_fb_data2,
               o_fb_data3, o_fb_data_vld, o_slot_full, o_rd_err
    );
endinterface
`default_nettype wire

// File: rtl/filter_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : filter_pingpong_buffer
// Brief    : Two-slot ping-pong filter buffer. The loader fills one slot lane
//            by lane while the PE engine reads the other with 1-cycle latency.
// Revision : 1.0
// ============================================================================
module filter_pingpong_buffer #(
    parameter int FILTER_DW     = 72,
    parameter int FILTER_BUF_AW = 8,
    parameter int Tin           = 4,
    parameter int Tout          = 4,
    parameter int W_SIZE        = 16
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    filter_pingpong_buffer_if.slave bus
);
    localparam int                    c_BANK_W  = $clog2(Tout);
    localparam int                    c_TL_W    = W_SIZE + $clog2(Tin);
    localparam int                    c_DEPTH   = 1 << FILTER_BUF_AW;
    localparam logic [c_BANK_W-1:0]   c_LAST_BANK = c_BANK_W'(Tout - 1);

    // Storage: slot x lane x address; contents are never reset
    logic [FILTER_DW-1:0] r_mem [0:1][0:Tout-1][0:c_DEPTH-1];

    logic [1:0]                        r_full;
    logic [1:0]                        w_full_next;
    logic                              r_wslot;
    logic                              r_rslot;
    logic [c_BANK_W-1:0]               r_bank_cnt;
    logic [FILTER_BUF_AW-1:0]          r_waddr;
    logic [1:0][c_TL_W-1:0]            r_slot_len;

    logic [Tout-1:0][FILTER_DW-1:0]    w_rd_word;
    logic [Tout-1:0][FILTER_DW-1:0]    r_rd_data;
    logic                              r_rd_vld;
    logic                              r_rd_err;

    logic                              w_accept;
    logic                              w_first_beat;
    logic                              w_last_beat;
    logic [c_TL_W-1:0]                 w_new_len;
    logic [c_TL_W-1:0]                 w_cur_len;
    logic                              w_release;
    logic                              w_rd_hit;
    logic                              w_addr_ok;

    // ---------------- write side ----------------
    assign bus.o_w_ready = ~r_full[r_wslot];
    assign w_accept      = bus.i_w_valid & ~r_full[r_wslot];
    assign w_first_beat  = (r_waddr == '0) && (r_bank_cnt == '0);
    assign w_new_len     = c_TL_W'(bus.q_channel) * c_TL_W'(Tin);
    // The first beat of a tile uses the live q_channel; later beats the latched length
    assign w_cur_len     = w_first_beat ? w_new_len : r_slot_len[r_wslot];
    assign w_last_beat   = w_accept && (r_bank_cnt == c_LAST_BANK) &&
                           (c_TL_W'(r_waddr) == (w_cur_len - c_TL_W'(1)));

    // Store accepted beats into the slot currently being filled
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wslot][r_bank_cnt][r_waddr] <= bus.i_w_data;
        end
    end

    // Lane/address counters, per-slot tile length and fill-slot pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wslot    <= 1'b0;
            r_bank_cnt <= '0;
            r_waddr    <= '0;
            r_slot_len <= '0;
        end else if (w_accept) begin
            if (w_first_beat) begin
                r_slot_len[r_wslot] <= w_new_len;
            end
            if (w_last_beat) begin
                r_bank_cnt <= '0;
                r_waddr    <= '0;
                r_wslot    <= ~r_wslot;
            end else if (r_bank_cnt == c_LAST_BANK) begin
                r_bank_cnt <= '0;
                r_waddr    <= r_waddr + FILTER_BUF_AW'(1);
            end else begin
                r_bank_cnt <= r_bank_cnt + c_BANK_W'(1);
            end
        end
    end

    // ---------------- slot ownership ----------------
    // Fill completion and release always target different slots, so both apply
    assign w_release = bus.i_tile_release & r_full[r_rslot];

    // Next full flags from fill completion and release
    always_comb begin
        w_full_next = r_full;
        if (w_last_beat) begin
            w_full_next[r_wslot] = 1'b1;
        end
        if (w_release) begin
            w_full_next[r_rslot] = 1'b0;
        end
    end

    // Full flags and read-slot pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_full  <= 2'b00;
            r_rslot <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_release) begin
                r_rslot <= ~r_rslot;
            end
        end
    end

    // ---------------- read side ----------------
    assign w_rd_hit  = bus.i_fb_req & r_full[r_rslot];
    assign w_addr_ok = c_TL_W'(bus.i_fb_addr) < r_slot_len[r_rslot];

    generate
        for (genvar gi = 0; gi < Tout; gi++) begin : g_lane
            assign w_rd_word[gi] = r_mem[r_rslot][gi][bus.i_fb_addr];
        end
    endgenerate

    // Registered read port; a same-cycle release still reads the old slot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_err  <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_hit;
            if (w_rd_hit) begin
                r_rd_data <= w_addr_ok ? w_rd_word : '0;
            end
            if (bus.i_fb_req && !r_full[r_rslot]) begin
                r_rd_err <= 1'b1;
            end
        end
    end

    assign bus.o_fb_req_possible = r_full[r_rslot];
    assign bus.o_fb_data0        = r_rd_data[0];
    assign bus.o_fb_data1        = r_rd_data[1];
    assign bus.o_fb_data2        = r_rd_data[2];
    assign bus.o_fb_data3        = r_rd_data[3];
    assign bus.o_fb_data_vld     = r_rd_vld;
    assign bus.o_slot_full       = r_full;
    assign bus.o_rd_err          = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_filter_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_pingpong_buffer
// Brief    : Directed self-checking bench for filter_pingpong_buffer.
// Revision : 1.0
// ============================================================================
module tb_filter_pingpong_buffer;
    localparam int FILTER_DW     = 72;
    localparam int FILTER_BUF_AW = 8;
    localparam int W_SIZE        = 16;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;

    filter_pingpong_buffer_if #(
        .FILTER_DW    (FILTER_DW),
        .FILTER_BUF_AW(FILTER_BUF_AW),
        .W_SIZE       (W_SIZE)
    ) bus ();

    filter_pingpong_buffer #(
        .FILTER_DW    (FILTER_DW),
        .FILTER_BUF_AW(FILTER_BUF_AW),
        .Tin          (4),
        .Tout         (4),
        .W_SIZE       (W_SIZE)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive reset and idle inputs; returns 1 time unit after a rising edge
    task automatic do_reset;
        rstn               = 1'b0;
        bus.q_channel      = '0;
        bus.i_w_valid      = 1'b0;
        bus.i_w_data       = '0;
        bus.i_fb_req       = 1'b0;
        bus.i_fb_addr      = '0;
        bus.i_tile_release = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Stream n beats with data base+i, waiting (bounded) on ready
    task automatic send_beats(input int n, input int base);
        int tmo;
        for (int i = 0; i < n; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w_data  = FILTER_DW'(base + i);
            tmo = 0;
            while (bus.o_w_ready !== 1'b1 && tmo < 50) begin
                @(posedge clk); #1;
                tmo++;
            end
            if (tmo >= 50) begin
                n_cmp++; n_err++;
                $display("FAIL beat_timeout: beat %0d ready=%b required 1", base + i, bus.o_w_ready);
            end
            @(posedge clk); #1;
        end
        bus.i_w_valid = 1'b0;
    endtask

    task automatic release_pulse;
        bus.i_tile_release = 1'b1;
        @(posedge clk); #1;
        bus.i_tile_release = 1'b0;
    endtask

    task automatic read_addr(input int a);
        bus.i_fb_req  = 1'b1;
        bus.i_fb_addr = FILTER_BUF_AW'(a);
        @(posedge clk); #1;
        bus.i_fb_req  = 1'b0;
    endtask

    // Reset state and first full tile in slot 0
    task automatic test_reset_fill;
        do_reset();
        n_cmp++; if (bus.o_slot_full !== 2'b00) begin n_err++; $display("FAIL rst_full: got %b required 00", bus.o_slot_full); end
        n_cmp++; if (bus.o_w_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b required 1", bus.o_w_ready); end
        n_cmp++; if (bus.o_fb_req_possible !== 1'b0) begin n_err++; $display("FAIL rst_reqpos: got %b required 0", bus.o_fb_req_possible); end
        n_cmp++; if (bus.o_fb_data_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b required 0", bus.o_fb_data_vld); end
        n_cmp++; if (bus.o_rd_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b required 0", bus.o_rd_err); end
        n_cmp++; if (bus.o_fb_data0 !== 72'd0) begin n_err++; $display("FAIL rst_data0: got %0d required 0", bus.o_fb_data0); end
        bus.q_channel = 16'd2;
        send_beats(31, 0);
        n_cmp++; if (bus.o_slot_full !== 2'b00) begin n_err++; $display("FAIL fill_early: got %b required 00", bus.o_slot_full); end
        send_beats(1, 31);
        n_cmp++; if (bus.o_slot_full !== 2'b01) begin n_err++; $display("FAIL fill_full: got %b required 01", bus.o_slot_full); end
        n_cmp++; if (bus.o_fb_req_possible !== 1'b1) begin n_err++; $display("FAIL fill_reqpos: got %b required 1", bus.o_fb_req_possible); end
        n_cmp++; if (bus.o_w_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready: got %b required 1", bus.o_w_ready); end
    endtask

    // Single read and back-to-back reads from slot 0
    task automatic test_read;
        read_addr(3);
        n_cmp++; if (bus.o_fb_data_vld !== 1'b1) begin n_err++; $display("FAIL rd_vld: got %b required 1", bus.o_fb_data_vld); end
        n_cmp++; if (bus.o_fb_data0 !== 72'd12) begin n_err++; $display("FAIL rd_d0: got %0d required 12", bus.o_fb_data0); end
        n_cmp++; if (bus.o_fb_data1 !== 72'd13) begin n_err++; $display("FAIL rd_d1: got %0d required 13", bus.o_fb_data1); end
        n_cmp++; if (bus.o_fb_data2 !== 72'd14) begin n_err++; $display("FAIL rd_d2: got %0d required 14", bus.o_fb_data2); end
        n_cmp++; if (bus.o_fb_data3 !== 72'd15) begin n_err++; $display("FAIL rd_d3: got %0d required 15", bus.o_fb_data3); end
        bus.i_fb_req = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus.i_fb_addr = FILTER_BUF_AW'(a);
            @(posedge clk); #1;
            n_cmp++; if (bus.o_fb_data_vld !== 1'b1) begin n_err++; $display("FAIL b2b_vld: addr %0d got %b required 1", a, bus.o_fb_data_vld); end
            n_cmp++; if (bus.o_fb_data0 !== FILTER_DW'(4 * a)) begin n_err++; $display("FAIL b2b_d0: addr %0d got %0d required %0d", a, bus.o_fb_data0, 4 * a); end
            n_cmp++; if (bus.o_fb_data3 !== FILTER_DW'(4 * a + 3)) begin n_err++; $display("FAIL b2b_d3: addr %0d got %0d required %0d", a, bus.o_fb_data3, 4 * a + 3); end
        end
        bus.i_fb_req = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.o_fb_data_vld !== 1'b0) begin n_err++; $display("FAIL idle_vld: got %b required 0", bus.o_fb_data_vld); end
        n_cmp++; if (bus.o_fb_data0 !== 72'd28) begin n_err++; $display("FAIL idle_hold: got %0d required 28", bus.o_fb_data0); end
    endtask

    // Both slots full: stall, release, read from slot 1
    task automatic test_both_full;
        send_beats(32, 100);
        n_cmp++; if (bus.o_slot_full !== 2'b11) begin n_err++; $display("FAIL both_full: got %b required 11", bus.o_slot_full); end
        n_cmp++; if (bus.o_w_ready !== 1'b0) begin n_err++; $display("FAIL both_ready: got %b required 0", bus.o_w_ready); end
        bus.i_w_valid = 1'b1;
        bus.i_w_data  = 72'd999;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.o_w_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b required 0", bus.o_w_ready); end
        n_cmp++; if (bus.o_slot_full !== 2'b11) begin n_err++; $display("FAIL stall_full: got %b required 11", bus.o_slot_full); end
        bus.i_w_valid = 1'b0;
        release_pulse();
        n_cmp++; if (bus.o_slot_full !== 2'b10) begin n_err++; $display("FAIL rel_full: got %b required 10", bus.o_slot_full); end
        n_cmp++; if (bus.o_w_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b required 1", bus.o_w_ready); end
        n_cmp++; if (bus.o_fb_req_possible !== 1'b1) begin n_err++; $display("FAIL rel_reqpos: got %b required 1", bus.o_fb_req_possible); end
        read_addr(2);
        n_cmp++; if (bus.o_fb_data0 !== 72'd108) begin n_err++; $display("FAIL s1_d0: got %0d required 108", bus.o_fb_data0); end
        n_cmp++; if (bus.o_fb_data3 !== 72'd111) begin n_err++; $display("FAIL s1_d3: got %0d required 111", bus.o_fb_data3); end
    endtask

    // Request and release with both slots empty
    task automatic test_rd_err;
        do_reset();
        read_addr(0);
        n_cmp++; if (bus.o_fb_data_vld !== 1'b0) begin n_err++; $display("FAIL err_vld: got %b required 0", bus.o_fb_data_vld); end
        n_cmp++; if (bus.o_rd_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b required 1", bus.o_rd_err); end
        n_cmp++; if (bus.o_fb_data0 !== 72'd0) begin n_err++; $display("FAIL err_hold: got %0d required 0", bus.o_fb_data0); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.o_rd_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b required 1", bus.o_rd_err); end
        release_pulse();
        n_cmp++; if (bus.o_slot_full !== 2'b00) begin n_err++; $display("FAIL empty_rel_full: got %b required 00", bus.o_slot_full); end
        n_cmp++; if (bus.o_fb_req_possible !== 1'b0) begin n_err++; $display("FAIL empty_rel_reqpos: got %b required 0", bus.o_fb_req_possible); end
    endtask

    // Out-of-range address on a slot holding stale data, then release+read together
    task automatic test_oob_release;
        bus.q_channel = 16'd3;
        send_beats(48, 400);          // slot 0, tile_len 12
        bus.q_channel = 16'd2;
        send_beats(32, 600);          // slot 1, tile_len 8
        release_pulse();              // free slot 0, rslot -> 1
        send_beats(32, 200);          // slot 0 again, tile_len 8
        release_pulse();              // free slot 1, rslot -> 0
        n_cmp++; if (bus.o_slot_full !== 2'b01) begin n_err++; $display("FAIL oob_full: got %b required 01", bus.o_slot_full); end
        read_addr(9);
        n_cmp++; if (bus.o_fb_data_vld !== 1'b1) begin n_err++; $display("FAIL oob_vld: got %b required 1", bus.o_fb_data_vld); end
        n_cmp++; if (bus.o_fb_data0 !== 72'd0) begin n_err++; $display("FAIL oob_d0: got %0d required 0", bus.o_fb_data0); end
        n_cmp++; if (bus.o_fb_data2 !== 72'd0) begin n_err++; $display("FAIL oob_d2: got %0d required 0", bus.o_fb_data2); end
        bus.i_tile_release = 1'b1;
        read_addr(1);
        bus.i_tile_release = 1'b0;
        n_cmp++; if (bus.o_fb_data_vld !== 1'b1) begin n_err++; $display("FAIL relrd_vld: got %b required 1", bus.o_fb_data_vld); end
        n_cmp++; if (bus.o_fb_data0 !== 72'd204) begin n_err++; $display("FAIL relrd_d0: got %0d required 204", bus.o_fb_data0); end
        n_cmp++; if (bus.o_fb_data3 !== 72'd207) begin n_err++; $display("FAIL relrd_d3: got %0d required 207", bus.o_fb_data3); end
        n_cmp++; if (bus.o_slot_full !== 2'b00) begin n_err++; $display("FAIL relrd_full: got %b required 00", bus.o_slot_full); end
        n_cmp++; if (bus.o_fb_req_possible !== 1'b0) begin n_err++; $display("FAIL relrd_reqpos: got %b required 0", bus.o_fb_req_possible); end
    endtask

    // Reset in the middle of a fill, then a clean refill
    task automatic test_reset_midfill;
        do_reset();
        bus.q_channel = 16'd2;
        send_beats(17, 0);
        rstn = 1'b0;
        #1;
        n_cmp++; if (bus.o_slot_full !== 2'b00) begin n_err++; $display("FAIL mrst_full: got %b required 00", bus.o_slot_full); end
        n_cmp++; if (bus.o_w_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %b required 1", bus.o_w_ready); end
        n_cmp++; if (bus.o_fb_data_vld !== 1'b0) begin n_err++; $display("FAIL mrst_vld: got %b required 0", bus.o_fb_data_vld); end
        @(posedge clk); #1;
        rstn = 1'b1;
        send_beats(1, 300);
        bus.q_channel = 16'd5;        // must not disturb the tile in progress
        send_beats(30, 301);
        n_cmp++; if (bus.o_slot_full !== 2'b00) begin n_err++; $display("FAIL refill_early: got %b required 00", bus.o_slot_full); end
        send_beats(1, 331);
        n_cmp++; if (bus.o_slot_full !== 2'b01) begin n_err++; $display("FAIL refill_full: got %b required 01", bus.o_slot_full); end
        n_cmp++; if (bus.o_rd_err !== 1'b0) begin n_err++; $display("FAIL refill_err: got %b required 0", bus.o_rd_err); end
        read_addr(7);
        n_cmp++; if (bus.o_fb_data0 !== 72'd328) begin n_err++; $display("FAIL refill_d0: got %0d required 328", bus.o_fb_data0); end
        n_cmp++; if (bus.o_fb_data3 !== 72'd331) begin n_err++; $display("FAIL refill_d3: got %0d required 331", bus.o_fb_data3); end
        read_addr(0);
        n_cmp++; if (bus.o_fb_data1 !== 72'd301) begin n_err++; $display("FAIL refill_a0d1: got %0d required 301", bus.o_fb_data1); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        test_reset_fill();
        test_read();
        test_both_full();
        test_rd_err();
        test_oob_release();
        test_reset_midfill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
